// File: rtl/alu16_req_scheduler_pkg.sv
// Shared types and 74181 encodings for the request scheduler.
// State enum for the sequencing FSM plus select/mode/carry constants.
package alu16_req_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_XOR    = 4'b0110;
    localparam logic       MODE_LOGIC = 1'b1;
    localparam logic       MODE_ARITH = 1'b0;
    // Raw 74181 Cn polarity: high means no carry into the slice.
    localparam logic       CIN_NONE   = 1'b1;

endpackage

// File: rtl/alu16_req_scheduler_rr.sv
// Round-robin arbiter: grants the first requester above ptr, wrapping.
// Latency: combinational. Backpressure: grant is forced to zero when en is low.
// Pointer ownership stays with the caller; this block only searches.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu16_req_scheduler.sv
// Shares one 16-bit 74181/74182 ALU between NREQ requesters, round-robin.
// Latency: accept at T -> rsp_valid at T+2 (16-bit) or T+3 (32-bit, two passes).
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
module alu16_req_scheduler
    import alu16_req_scheduler_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*4-1:0] req_sel,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_wide,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_result,
    output logic              rsp_cout,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_sel,
    output logic              alu_mode,
    output logic              alu_cin,
    input  logic [15:0]       alu_result,
    input  logic              alu_cout
);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, arb_idx, lat_id;
    logic [NREQ-1:0] arb_grant;
    logic            accept;
    logic [31:0]     lat_a, lat_b, res;
    logic [3:0]      lat_sel;
    logic            lat_mode, lat_cin, lat_wide, carry_reg, cout_reg;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign accept     = |arb_grant;
    assign req_ready  = arb_grant;
    assign rsp_valid  = (state == RSP);
    assign rsp_id     = lat_id;
    assign rsp_result = res;
    assign rsp_cout   = cout_reg;

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        alu_mode  = 1'b0;
        alu_cin   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = LO;
            LO: begin
                state_nxt = lat_wide ? HI : RSP;
                alu_a     = lat_a[15:0];
                alu_b     = lat_b[15:0];
                alu_sel   = lat_sel;
                alu_mode  = lat_mode;
                alu_cin   = lat_cin;
            end
            HI: begin
                // Raw active-low Cn+4 of the low pass feeds the active-low Cn directly.
                state_nxt = RSP;
                alu_a     = lat_a[31:16];
                alu_b     = lat_b[31:16];
                alu_sel   = lat_sel;
                alu_mode  = lat_mode;
                alu_cin   = carry_reg;
            end
            RSP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            lat_id    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_sel   <= '0;
            lat_mode  <= 1'b0;
            lat_cin   <= 1'b0;
            lat_wide  <= 1'b0;
            res       <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    ptr      <= arb_idx;
                    lat_id   <= arb_idx;
                    lat_a    <= req_a[32*arb_idx +: 32];
                    lat_b    <= req_b[32*arb_idx +: 32];
                    lat_sel  <= req_sel[4*arb_idx +: 4];
                    lat_mode <= req_mode[arb_idx];
                    lat_cin  <= req_cin[arb_idx];
                    lat_wide <= req_wide[arb_idx];
                end
                LO: begin
                    res       <= {16'h0000, alu_result};
                    carry_reg <= alu_cout;
                    cout_reg  <= alu_cout;
                end
                HI: begin
                    res[31:16] <= alu_result;
                    cout_reg   <= alu_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_req_scheduler.sv
// Bench for alu16_req_scheduler: 16-bit 74181 stand-in, transaction-level model, directed + random.
module tb_alu16_req_scheduler;
    import alu16_req_scheduler_pkg::*;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_mode, req_cin, req_wide;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ*4-1:0] req_sel;
    logic              rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic [15:0]       alu_a, alu_b, alu_result;
    logic [3:0]        alu_sel;
    logic              alu_mode, alu_cin, alu_cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    alu16_req_scheduler #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .req_mode(req_mode), .req_cin(req_cin), .req_wide(req_wide),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_mode(alu_mode),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 74181 datasheet behaviour, active-high data, width w (16 or 32).
    // Returns {raw Cn+w, F}. Carry out does not depend on mode, as on the chip.
    function automatic logic [32:0] alu181(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] s, input logic m,
                                           input logic cin, input int w);
        logic [31:0] msk, t, u, f;
        logic [32:0] sum;
        logic        cy;
        msk = (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
        t   = (a | (b & {32{s[0]}}) | (~b & {32{s[1]}})) & msk;
        u   = ((a & ~b & {32{s[2]}}) | (a & b & {32{s[3]}})) & msk;
        sum = {1'b0, t} + {1'b0, u} + {32'b0, ~cin};
        cy  = (w == 16) ? sum[16] : sum[32];
        f   = m ? (~(t ^ u) & msk) : (sum[31:0] & msk);
        return {~cy, f};
    endfunction

    logic [32:0] alu_r33;
    always_comb begin
        alu_r33    = alu181({16'h0, alu_a}, {16'h0, alu_b}, alu_sel, alu_mode, alu_cin, 16);
        alu_result = alu_r33[15:0];
        alu_cout   = alu_r33[32];
    end

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } cmp_t;
    cmp_t cmpq[$];

    task automatic push(input string nm, input logic [63:0] a, input logic [63:0] e);
        cmp_t c;
        c.name = nm; c.act = a; c.exp = e;
        cmpq.push_back(c);
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Transaction-level model: one op in flight, a pass count, a pointer.
    bit          m_busy, m_rsp, m_wide, m_mode, m_cin, hi;
    int          m_left, m_ptr, m_id, win;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_sel;
    logic [32:0] m_exp, lo_r;
    logic [NREQ-1:0] e_ready;
    logic [15:0] e_a, e_b;
    logic [3:0]  e_sel;
    logic        e_mode, e_cin;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_cin", alu_cin, 0);
            m_busy = 0; m_rsp = 0; m_left = 0; m_ptr = NREQ - 1;
        end else begin
            e_ready = '0; e_a = 0; e_b = 0; e_sel = 0; e_mode = 0; e_cin = 0; win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NREQ; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                if (win >= 0) e_ready[win] = 1'b1;
            end else if (m_left > 0) begin
                hi     = m_wide && (m_left == 1);
                lo_r   = alu181({16'h0, m_a[15:0]}, {16'h0, m_b[15:0]}, m_sel, m_mode, m_cin, 16);
                e_a    = hi ? m_a[31:16] : m_a[15:0];
                e_b    = hi ? m_b[31:16] : m_b[15:0];
                e_sel  = m_sel;
                e_mode = m_mode;
                e_cin  = hi ? lo_r[32] : m_cin;
            end
            chk("req_ready", req_ready, e_ready);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_sel", alu_sel, e_sel);
            chk("alu_mode", alu_mode, e_mode);
            chk("alu_cin", alu_cin, e_cin);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_exp[31:0]);
                chk("rsp_cout", rsp_cout, m_exp[32]);
            end
            if (!m_busy) begin
                if (win >= 0) begin
                    m_a    = req_a[32*win +: 32];
                    m_b    = req_b[32*win +: 32];
                    m_sel  = req_sel[4*win +: 4];
                    m_mode = req_mode[win];
                    m_cin  = req_cin[win];
                    m_wide = req_wide[win];
                    m_id   = win;
                    m_ptr  = win;
                    m_exp  = alu181(m_a, m_b, m_sel, m_mode, m_cin, m_wide ? 32 : 16);
                    m_busy = 1; m_left = m_wide ? 2 : 1;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_rsp = 1;
            end else if (rsp_ready) begin
                m_busy = 0; m_rsp = 0;
            end
        end
        while (cmpq.size() > 0) begin
            cmp_t c;
            c = cmpq.pop_front();
            chk(c.name, c.act, c.exp);
        end
    end

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s, input logic m, input logic cin, input logic w);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_sel[4*r +: 4] = s;
        req_mode[r] = m;
        req_cin[r]  = cin;
        req_wide[r] = w;
    endtask

    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic m, input logic cin, input logic w,
                         input logic [31:0] er, input logic ec, input int elat,
                         input string nm, output int wt);
        int  t0;
        bit  ok;
        @(posedge clk); #2;
        set_req(r, a, b, s, m, cin, w);
        req_valid[r] = 1'b1;
        ok = 0; wt = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); wt++; ok = req_ready[r];
        end
        if (!ok) push({nm, "_accept_timeout"}, 0, 1);
        t0 = cyc;
        @(posedge clk); #2;
        req_valid[r] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = rsp_valid;
        end
        if (!ok) push({nm, "_rsp_timeout"}, 0, 1);
        push({nm, "_latency"}, cyc - t0, elat);
        push({nm, "_result"}, rsp_result, er);
        push({nm, "_cout"}, rsp_cout, ec);
        push({nm, "_id"}, rsp_id, r);
    endtask

    int          wt;
    int          gseq[$];
    bit          ok;
    logic [NREQ-1:0] got;
    logic [31:0] ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
        req_mode = '0; req_cin = '0; req_wide = '0;
        repeat (3) @(posedge clk);
        #1;
        push("reset_rsp_result", rsp_result, 0);
        push("reset_rsp_id", rsp_id, 0);
        push("reset_alu_b", alu_b, 0);
        #3 rst_n = 1'b1;

        // req1 alone after reset is granted on its first cycle.
        do_op(1, 32'h0000_0003, 32'h0000_0004, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b0,
              32'h0000_0007, 1'b1, 2, "req1_first", wt);
        push("req1_first_wait", wt, 1);
        do_op(0, 32'h0000_1234, 32'h0000_0001, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b0,
              32'h0000_1235, 1'b1, 2, "narrow_add", wt);
        do_op(0, 32'h0000_FFFF, 32'h0000_0001, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b1,
              32'h0001_0000, 1'b1, 3, "wide_carry", wt);
        do_op(2, 32'hF0F0_AAAA, 32'hFFFF_5555, SEL_XOR, MODE_LOGIC, CIN_NONE, 1'b1,
              32'h0F0F_FFFF, 1'b1, 3, "wide_xor", wt);

        // Round-robin with req0 and req1 continuously valid; pointer is at 2 here.
        @(posedge clk); #2;
        set_req(0, 32'h10, 32'h1, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b0);
        set_req(1, 32'h20, 32'h2, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b1);
        req_valid[1:0] = 2'b11;
        for (int i = 0; i < 40 && gseq.size() < 4; i++) begin
            @(negedge clk);
            if (req_ready[0]) gseq.push_back(0);
            if (req_ready[1]) gseq.push_back(1);
        end
        @(posedge clk); #2;
        req_valid = '0;
        push("rr_count", gseq.size(), 4);
        for (int i = 0; i < 4; i++)
            push($sformatf("rr_grant%0d", i), (i < gseq.size()) ? gseq[i] : 99, i % 2);
        repeat (6) @(posedge clk);

        // Backpressure: response held 5 cycles, pending req1 waits.
        #2;
        rsp_ready = 1'b0;
        set_req(0, 32'h5, 32'h7, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b0);
        set_req(1, 32'h0000_00FF, 32'h0000_000F, SEL_XOR, MODE_LOGIC, CIN_NONE, 1'b0);
        req_valid[1:0] = 2'b11;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = req_ready[0];
        end
        if (!ok) push("bp_accept_timeout", 0, 1);
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = rsp_valid;
        end
        if (!ok) push("bp_rsp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push("bp_hold_valid", rsp_valid, 1);
            push("bp_hold_result", rsp_result, 32'h0000_000C);
            push("bp_hold_id", rsp_id, 0);
            push("bp_hold_ready", req_ready, 0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        push("bp_no_accept_on_handshake", req_ready, 0);
        @(negedge clk);
        push("bp_req1_after_idle", req_ready, 3'b010);
        @(posedge clk); #2;
        req_valid[1] = 1'b0;
        repeat (5) @(posedge clk);

        // Reset during the high pass of a wide op.
        #2;
        set_req(2, 32'h1234_8001, 32'h4321_7FFF, SEL_ADD, MODE_ARITH, CIN_NONE, 1'b1);
        req_valid[2] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = req_ready[2];
        end
        if (!ok) push("rst_mid_accept_timeout", 0, 1);
        @(posedge clk); #2;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        push("rst_mid_hi_alu_a", alu_a, 16'h1234);
        #3 rst_n = 1'b0;
        #1;
        push("rst_mid_alu_a", alu_a, 0);
        push("rst_mid_alu_b", alu_b, 0);
        push("rst_mid_alu_sel", alu_sel, 0);
        push("rst_mid_alu_cin", alu_cin, 0);
        push("rst_mid_rsp_valid", rsp_valid, 0);
        push("rst_mid_rsp_result", rsp_result, 0);
        push("rst_mid_rsp_cout", rsp_cout, 0);
        push("rst_mid_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push("rst_mid_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #2;
        req_valid[1:0] = 2'b11;
        @(negedge clk);
        push("rst_mid_req0_wins", req_ready, 3'b001);
        @(posedge clk); #2;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Random traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (got[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    ra = $urandom;
                    if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFF;
                    set_req(i, ra, $urandom, 4'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        got = req_ready;
        @(posedge clk); #2;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu16_req_scheduler.md
Name: alu16_req_scheduler

Overview:
- Shares one 16-bit 74181/74182 ALU datapath between NREQ requesters.
- Arbitrates round-robin and latches the winning operation.
- Sequences the operation through the ALU: one pass for 16-bit ops, two carry-chained passes for 32-bit ops.
- Returns the result on a single valid/ready response port tagged with the requester index.
- Sits between client engines and the combinational 16-bit ALU instance, which it drives through its alu_* ports.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (minimum 1), width of rsp_id

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
req_a  in  NREQ*32  operand A, requester i at [32*i +: 32]
req_b  in  NREQ*32  operand B, same packing
req_sel  in  NREQ*4  74181 function select, [4*i +: 4]
req_mode  in  NREQ  74181 mode (1 = logic, 0 = arithmetic)
req_cin  in  NREQ  carry in, raw 74181 Cn polarity (1 = no carry)
req_wide  in  NREQ  1 = 32-bit op, 0 = 16-bit op
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted by consumer
rsp_id  out  IDW  index of the requester that issued the op
rsp_result  out  32  result; bits [31:16] are 0 for 16-bit ops
rsp_cout  out  1  final raw 74181 Cn+4 of the last pass
alu_a  out  16  to ALU operand A
alu_b  out  16  to ALU operand B
alu_sel  out  4  to ALU select
alu_mode  out  1  to ALU mode
alu_cin  out  1  to ALU carry in
alu_result  in  16  from ALU result
alu_cout  in  1  from ALU Cout

Behaviour:
- FSM states: IDLE, LO, HI, RSP. Reset state is IDLE.
- On reset, all outputs are 0, all operation registers are cleared, and the round-robin pointer is NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid is high, the arbiter picks the first valid index searching from pointer+1 upward, wrapping modulo NREQ.
  - The granted req_ready is 1 for this one cycle.
  - The scheduler latches a, b, sel, mode, cin, wide and id, sets pointer = granted index, and goes to LO.
  - If no request is valid, it stays in IDLE with req_ready = 0.
- req_ready is 0 in every state other than IDLE. Requesters must hold valid and data stable until they see ready.
- LO:
  - Drives alu_a/alu_b with latched [15:0], alu_sel/alu_mode from the latch, and alu_cin = latched cin.
  - At the clock edge: result[15:0] <= alu_result and carry_reg <= alu_cout.
  - Goes to HI if wide, else to RSP with result[31:16] = 0 and rsp_cout = alu_cout.
- HI:
  - Drives latched [31:16], same sel/mode, and alu_cin = carry_reg. The raw carry is passed unchanged; active-low out feeds active-low in.
  - At the clock edge: result[31:16] <= alu_result and rsp_cout <= alu_cout; go to RSP.
- Logic mode (mode = 1): carries are still chained, the ALU ignores them, and rsp_cout reports whatever the ALU returns.
- RSP:
  - rsp_valid = 1; rsp_id, rsp_result and rsp_cout stay stable until rsp_valid && rsp_ready, then the FSM goes to IDLE.
  - No accept is allowed in the same cycle as the response handshake.
- Latency: with the accept in cycle T, rsp_valid rises at T+2 for 16-bit ops and T+3 for 32-bit ops.
- Throughput: at most one op in flight. The minimum request-to-request spacing is 3 cycles (narrow) or 4 cycles (wide) with rsp_ready held high.
- alu_* outputs are 0 in IDLE and RSP.
- The pointer updates only on an accept; requests that are valid but lose arbitration do not move it.
- Asserting rst_n low mid-operation abandons the op: no response is produced, the FSM returns to IDLE and the pointer resets.
- The response registers and the FSM are flops; alu_* outputs are combinational from state and the latch (the ALU path is single-cycle combinational).

Decomposition:
- Shared package holds: the state enum (IDLE/LO/HI/RSP); the 74181 select constants used by the bench (SEL_ADD = 4'b1001, SEL_XOR = 4'b0110); MODE_LOGIC = 1, MODE_ARITH = 0; CIN_NONE = 1.
- One sub-module, rr_arbiter (NREQ parameter): inputs req vector, pointer and enable; outputs one-hot grant and encoded index.

Test Plan:
- Narrow add: req0 a = 0x1234, b = 0x0001, sel = 1001, mode = 0, cin = 1, wide = 0 -> rsp at T+2 with result 0x00001235, rsp_cout = 1, id = 0.
- Wide carry chain: a = 0x0000FFFF, b = 0x00000001, ADD, cin = 1, wide = 1 -> LO pass gives cout = 0; HI cin = 0; result 0x00010000, rsp_cout = 1, rsp at T+3.
- Logic XOR wide: a = 0xF0F0AAAA, b = 0xFFFF5555, sel = 0110, mode = 1 -> result 0x0F0FFFFF.
- Round-robin: req0 and req1 held continuously valid -> grants/rsp_id sequence 0, 1, 0, 1; req1 alone after reset -> granted immediately.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid/result/id held stable, req_ready stays 0 for a pending req1, which is accepted the cycle after the handshake returns to IDLE.
- Reset mid-op: drop rst_n during HI -> all outputs 0 immediately, no rsp_valid after release, next request to req0 wins.
